// File: rtl/trng_ctrl_pkg.sv
// Shared types, default parameters and counter sizing for the TRNG sequencer.
// StFail exists only when TRNG_CTRL_HEALTH_EN is defined.
package trng_ctrl_pkg;

  localparam int unsigned DefWordWidth    = 32;
  localparam int unsigned DefWarmupCycles = 256;
  localparam int unsigned DefSampleDiv    = 4;
  localparam int unsigned DefRepLimit     = 34;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StCollect,
    StHold
`ifdef TRNG_CTRL_HEALTH_EN
    ,
    StFail
`endif
  } trng_ctrl_state_e;

  // Width of a counter that runs 0..terminal-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/trng_ctrl_if.sv
// Bus/macro-facing signal bundle of trng_ctrl; master is the controller side.
interface trng_ctrl_if
  import trng_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefWordWidth
);

  logic                  enable;
  logic                  trng_en;
  logic                  trng_bit;
  logic [WORD_WIDTH-1:0] rnd_data;
  logic                  rnd_valid;
  logic                  rnd_ready;
  logic                  busy;
  logic                  health_fail;

  modport master (
    input  enable, trng_bit, rnd_ready,
    output trng_en, rnd_data, rnd_valid, busy, health_fail
  );

  modport slave (
    output enable, trng_bit, rnd_ready,
    input  trng_en, rnd_data, rnd_valid, busy, health_fail
  );

endinterface

// File: rtl/trng_health_rct.sv
// Repetition-count health test: flags a run of REP_LIMIT identical samples.
// fail is a combinational strobe on the sample that completes the run.
module trng_health_rct
  import trng_ctrl_pkg::*;
#(
  parameter int unsigned REP_LIMIT = DefRepLimit
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_stb,
  input  logic bit_in,
  output logic fail
);

  localparam logic [7:0] RepLimit = 8'(REP_LIMIT);

  logic       r_last;
  logic [7:0] r_run;
  logic [7:0] w_run_nxt;

  always_comb begin
    w_run_nxt = 8'd1;
    if ((r_run != 8'd0) && (bit_in == r_last)) begin
      w_run_nxt = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
    end
  end

  assign fail = sample_stb && (w_run_nxt >= RepLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
      r_run  <= 8'd0;
    end else if (clear) begin
      r_last <= 1'b0;
      r_run  <= 8'd0;
    end else if (sample_stb) begin
      r_last <= bit_in;
      r_run  <= w_run_nxt;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, divided sampling, word packing, valid/ready hand-off.
// Define TRNG_CTRL_HEALTH_EN to add the repetition-count test and the sticky FAIL state.
module trng_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DefWordWidth,
  parameter int unsigned WARMUP_CYCLES = DefWarmupCycles,
  parameter int unsigned SAMPLE_DIV    = DefSampleDiv,
  parameter int unsigned REP_LIMIT     = DefRepLimit
) (
  input logic         clk,
  input logic         rst_n,
  trng_ctrl_if.master bus
);

  localparam int unsigned WarmW = cnt_width(WARMUP_CYCLES);
  localparam int unsigned DivW  = cnt_width(SAMPLE_DIV);
  localparam int unsigned BitW  = cnt_width(WORD_WIDTH);

  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_WIDTH - 1);

  localparam bit ParamsOk = (WORD_WIDTH >= 2) && (WORD_WIDTH <= 64) && (WARMUP_CYCLES >= 1) &&
                            (SAMPLE_DIV >= 1) && (REP_LIMIT >= 2) && (REP_LIMIT <= 255);

  if (!ParamsOk) begin : g_bad_params
    $error("trng_ctrl: parameter out of range");
  end

  trng_ctrl_state_e      r_state, w_state_nxt;
  logic [WarmW-1:0]      r_warm_cnt;
  logic [DivW-1:0]       r_div;
  logic [BitW-1:0]       r_bit_cnt;
  logic [WORD_WIDTH-1:0] r_sr;
  logic                  r_trng_en, r_valid, r_busy;
  logic                  w_sample, w_discard;

  assign w_sample = (r_state == StCollect) && (r_div == DivLast);

`ifdef TRNG_CTRL_HEALTH_EN
  logic w_rct_clear, w_rct_fail, r_health_fail;

  // Run length restarts only on a fresh warm-up, so it spans word boundaries.
  assign w_rct_clear = (r_state == StWarmup) && (w_state_nxt == StCollect);
  assign w_discard   = (w_state_nxt == StIdle) || (w_state_nxt == StFail);

  trng_health_rct #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rct (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_rct_clear),
    .sample_stb (w_sample),
    .bit_in     (bus.trng_bit),
    .fail       (w_rct_fail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_health_fail <= 1'b0;
    else        r_health_fail <= (w_state_nxt == StFail);
  end

  assign bus.health_fail = r_health_fail;
`else
  assign w_discard       = (w_state_nxt == StIdle);
  assign bus.health_fail = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:    if (bus.enable) w_state_nxt = StWarmup;
      StWarmup:  if (r_warm_cnt == WarmLast) w_state_nxt = StCollect;
      StCollect: begin
        if (w_sample && (r_bit_cnt == BitLast)) w_state_nxt = StHold;
`ifdef TRNG_CTRL_HEALTH_EN
        if (w_rct_fail) w_state_nxt = StFail;
`endif
      end
      StHold:    if (bus.rnd_ready) w_state_nxt = StCollect;
      default:   ;
    endcase
    if (!bus.enable) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_warm_cnt <= '0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
      r_trng_en  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_warm_cnt <= ((r_state == StWarmup) && (w_state_nxt == StWarmup)) ?
                    r_warm_cnt + 1'b1 : '0;
      // Counters live only within one COLLECT stay; any exit clears them.
      if ((r_state == StCollect) && (w_state_nxt == StCollect)) begin
        r_div <= w_sample ? '0 : r_div + 1'b1;
        if (w_sample) r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_div     <= '0;
        r_bit_cnt <= '0;
      end
      if (w_discard)     r_sr <= '0;
      else if (w_sample) r_sr <= {r_sr[WORD_WIDTH-2:0], bus.trng_bit};
      r_trng_en <= (w_state_nxt == StWarmup) || (w_state_nxt == StCollect) ||
                   (w_state_nxt == StHold);
      r_valid   <= (w_state_nxt == StHold);
      r_busy    <= (w_state_nxt != StIdle);
    end
  end

  assign bus.trng_en   = r_trng_en;
  assign bus.rnd_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.rnd_data  = r_sr;

endmodule
